// File: rtl/rotate_pkg.sv
// Shared definitions for the forward and inverse rho lane-rotate stages.
// Holds geometry, the rho offset table and the controller state encoding.
package rotate_pkg;

    localparam int LINE_W = 25;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = 6;

    typedef logic [CNT_W-1:0] rho_t;

    // Lane i = x + 5y; offsets are z-rotations modulo 64.
    localparam rho_t RHO_OFFSET [0:LINE_W-1] = '{
        6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
        6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
        6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
        6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
        6'd18, 6'd2,  6'd61, 6'd56, 6'd14
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/inv_rotate_controller.sv
// Sequencer for the inverse rotate: IDLE -> LOAD (64) -> EMIT (64) -> DONE -> IDLE.
// Latency: 129 cycles start to done; no backpressure, start sampled only in IDLE.
module inv_rotate_controller
    import rotate_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic cnt_last_i,
    output logic cnt_clr_o,
    output logic cnt_inc_o,
    output logic buf_we_o,
    output logic write_enable_o,
    output logic done_o
);

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_clr_o = 1'b0;
        cnt_inc_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_LOAD;
                    cnt_clr_o = 1'b1;
                end
            end
            ST_LOAD: begin
                cnt_inc_o = 1'b1;
                if (cnt_last_i) begin
                    state_d   = ST_EMIT;
                    cnt_clr_o = 1'b1;
                end
            end
            ST_EMIT: begin
                cnt_inc_o = 1'b1;
                if (cnt_last_i) begin
                    state_d   = ST_DONE;
                    cnt_clr_o = 1'b1;
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                cnt_clr_o = 1'b1;
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_clr_o = 1'b1;
            end
        endcase
    end

    assign buf_we_o       = (state_q == ST_LOAD);
    assign write_enable_o = (state_q == ST_EMIT);
    assign done_o         = (state_q == ST_DONE);

endmodule

// File: rtl/inv_rotate_top.sv
// Inverse rho: buffers a 64x25 state, then writes out[z][i] = buf[(z + r[i]) mod 64][i].
// Latency: 129 cycles start to donee; no backpressure, memory must answer reads same cycle.
module inv_rotate_top
    import rotate_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inv_rotate_en,
    input  logic [LINE_W-1:0] line_in,
    output logic [CNT_W-1:0]  cnt_value,
    output logic              write_enable,
    output logic [LINE_W-1:0] write_value,
    output logic              donee
);

    logic              cnt_clr, cnt_inc, cnt_last, buf_we;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] buf_q [0:DEPTH-1];
    logic [LINE_W-1:0] unrot;

    inv_rotate_controller u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .start_i        (inv_rotate_en),
        .cnt_last_i     (cnt_last),
        .cnt_clr_o      (cnt_clr),
        .cnt_inc_o      (cnt_inc),
        .buf_we_o       (buf_we),
        .write_enable_o (write_enable),
        .done_o         (donee)
    );

    assign cnt_last = (cnt_q == CNT_W'(DEPTH - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Scratch buffer only; contents are meaningless outside a run, so no reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[cnt_q] <= line_in;
        end
    end

    for (genvar i = 0; i < LINE_W; i++) begin : g_lane
        logic [CNT_W-1:0] src;
        assign src      = cnt_q + RHO_OFFSET[i];
        assign unrot[i] = buf_q[src][i];
    end

    assign cnt_value   = cnt_q;
    assign write_value = write_enable ? unrot : '0;

endmodule

// File: tb/tb_inv_rotate_top.sv
// Directed bench for inv_rotate_top with a forward-rho reference and write scoreboard.
module tb_inv_rotate_top;

    localparam int RHO_T [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43,
                                  25, 39, 41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

    typedef struct packed {
        logic [5:0]  addr;
        logic [24:0] val;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [24:0] line_in;
    logic [5:0]  cnt_value;
    logic        write_enable;
    logic [24:0] write_value;
    logic        donee;

    logic [24:0] mem      [64];
    logic [24:0] orig_img [64];
    logic [24:0] exp_img  [64];
    wr_t         sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          writes   = 0;
    bit          mon_on   = 0;

    inv_rotate_top dut (
        .clk           (clk),
        .rst           (rst),
        .inv_rotate_en (en),
        .line_in       (line_in),
        .cnt_value     (cnt_value),
        .write_enable  (write_enable),
        .write_value   (write_value),
        .donee         (donee)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign line_in = mem[cnt_value];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // Scoreboard pops on every write strobe; outside EMIT the write data must be zero.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (mon_on) begin
            if (write_enable) begin
                writes++;
                chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("wr_addr", 32'(cnt_value), 32'(e.addr));
                    chk("wr_val", 32'(write_value), 32'(e.val));
                end
            end else begin
                chk("idle_wv_zero", 32'(write_value), 32'd0);
            end
        end
    end

    task automatic push_exp();
        for (int z = 0; z < 64; z++) sb_q.push_back(wr_t'{6'(z), exp_img[z]});
    endtask

    // Reference forward rho: mem[z][i] = orig[(z - r[i]) mod 64][i]; expected output is orig.
    task automatic forward_from_orig();
        for (int z = 0; z < 64; z++) begin
            exp_img[z] = orig_img[z];
            for (int i = 0; i < 25; i++) mem[z][i] = orig_img[(z - RHO_T[i] + 64) % 64][i];
        end
    endtask

    task automatic clear_imgs();
        for (int z = 0; z < 64; z++) begin
            mem[z]     = '0;
            exp_img[z] = '0;
        end
    endtask

    // Called at a negedge; start is sampled at the next posedge (edge 0).
    task automatic run(input bit toggle, output int cyc);
        en = 1'b1;
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("load_cnt0", 32'(cnt_value), 32'd0);
            en = (toggle && cyc < 64) ? cyc[0] : 1'b0;
        end while (!donee && cyc < 300);
    endtask

    initial begin : stim
        int cyc, w0, d1, d2;
        rst = 1'b1;
        en  = 1'b0;
        clear_imgs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cnt", 32'(cnt_value), 32'd0);
        chk("rst_we", 32'(write_enable), 32'd0);
        chk("rst_wv", 32'(write_value), 32'd0);
        chk("rst_done", 32'(donee), 32'd0);
        rst    = 1'b0;
        mon_on = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("idle_we", 32'(write_enable), 32'd0);
            chk("idle_done", 32'(donee), 32'd0);
            chk("idle_cnt", 32'(cnt_value), 32'd0);
        end
        chk("idle_writes", 32'(writes), 32'd0);

        // Lane 1 (r=1): line 5 bit 1 must land at z=4.
        clear_imgs();
        mem[5][1]  = 1'b1;
        exp_img[4] = 25'h0000002;
        push_exp();
        w0 = writes;
        run(1'b0, cyc);
        chk("lane1_done_lat", 32'(cyc), 32'd129);
        chk("lane1_writes", 32'(writes - w0), 32'd64);
        @(negedge clk);
        chk("lane1_done_pulse", 32'(donee), 32'd0);
        chk("lane1_sb_empty", 32'(sb_q.size()), 32'd0);

        // Lane 2 (r=62) wraps line 0 to z=2; lane 0 (r=0) keeps line 17 at z=17.
        clear_imgs();
        mem[0][2]   = 1'b1;
        mem[17][0]  = 1'b1;
        exp_img[2]  = 25'h0000004;
        exp_img[17] = 25'h0000001;
        push_exp();
        run(1'b0, cyc);
        chk("wrap_done_lat", 32'(cyc), 32'd129);
        @(negedge clk);
        chk("wrap_sb_empty", 32'(sb_q.size()), 32'd0);

        // Random round trip with en toggling during LOAD.
        for (int z = 0; z < 64; z++) orig_img[z] = 25'($urandom);
        forward_from_orig();
        push_exp();
        run(1'b1, cyc);
        chk("rand_done_lat", 32'(cyc), 32'd129);
        @(negedge clk);
        chk("rand_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("rand_no_restart", 32'(cnt_value), 32'd0);

        // All ones stays all ones.
        for (int z = 0; z < 64; z++) orig_img[z] = '1;
        forward_from_orig();
        push_exp();
        run(1'b0, cyc);
        chk("ones_done_lat", 32'(cyc), 32'd129);
        @(negedge clk);
        chk("ones_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset in EMIT at cycle 70, then a clean rerun.
        for (int z = 0; z < 64; z++) orig_img[z] = 25'($urandom);
        forward_from_orig();
        push_exp();
        w0 = writes;
        en = 1'b1;
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            en = 1'b0;
        end while (cyc < 70);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_we", 32'(write_enable), 32'd0);
        chk("abort_cnt", 32'(cnt_value), 32'd0);
        chk("abort_done", 32'(donee), 32'd0);
        chk("abort_writes", 32'(writes - w0), 32'd6);
        rst = 1'b0;
        sb_q.delete();
        d1 = 0;
        repeat (10) begin
            @(negedge clk);
            if (donee || write_enable) d1++;
        end
        chk("abort_quiet", 32'(d1), 32'd0);
        push_exp();
        run(1'b0, cyc);
        chk("rerun_done_lat", 32'(cyc), 32'd129);
        @(negedge clk);
        chk("rerun_sb_empty", 32'(sb_q.size()), 32'd0);

        // en held high: second run is sampled in the IDLE cycle right after DONE.
        for (int z = 0; z < 64; z++) orig_img[z] = 25'($urandom);
        forward_from_orig();
        push_exp();
        push_exp();
        w0 = writes;
        d1 = 0;
        d2 = 0;
        en = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 280; c++) begin
            @(negedge clk);
            if (donee) begin
                if (d1 == 0) d1 = c;
                else if (d2 == 0) d2 = c;
            end
            if (c == 130) begin
                chk("b2b_gap_done", 32'(donee), 32'd0);
                chk("b2b_gap_cnt", 32'(cnt_value), 32'd0);
            end
            if (c == 131) en = 1'b0;
        end
        chk("b2b_done1", 32'(d1), 32'd129);
        chk("b2b_done2", 32'(d2), 32'd259);
        chk("b2b_writes", 32'(writes - w0), 32'd128);
        chk("b2b_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
